maze_solver: RTL and testbench
==============================

// Module: maze_solver
// PURPOSE
//  Initiator side of the 16x16 maze-memory port. Depth-first rat controller: loads the map, then walks from (0,0) to (15,15).
//  Probes neighbours, marks each entered cell visited and backtracks via a direction stack.
//  Reports done/fail, path length and (optionally) replays the path.
// PARAMETERS
//  STACK_DEPTH  256  max stacked moves (one per cell); index width = $clog2(STACK_DEPTH)
//  GOAL_X       15   goal column
//  GOAL_Y       15   goal row
// PORTS
//  clk         in   1  clock, rising edge
//  rst         in   1  reset, asynchronous, active-high
//  start       in   1  one-cycle pulse, accepted only in IDLE
//  Dout        in   1  memory read data: 1 = wall/visited/out-of-bounds
//  Xm          out  5  probe/write column (5'd31 = -1, 5'd16 = out of range)
//  Ym          out  5  probe/write row
//  Din         out  1  write data, always 1 (mark visited)
//  readMap     out  1  one-cycle map load request
//  RD          out  1  read strobe; Dout sampled on same-cycle rising edge
//  WR          out  1  write strobe, memory writes on rising edge
//  done        out  1  level, goal reached
//  fail        out  1  level, no path exists
//  path_len    out  8  current stack depth (moves from start)
//  move_valid  out  1  replay strobe (PATH_REPLAY_EN only, else 0)
//  move_dir    out  2  replay direction
// BEHAVIOUR
//  - Reset: state IDLE, cur=(0,0), d=0, sp=0; all outputs 0.
//  - Dirs: 0=RIGHT(+X) 1=DOWN(+Y) 2=LEFT(-X) 3=UP(-Y). Neighbour is 5-bit add/sub, wraps (0-1=31).
//  - Memory Dout is combinational; controller samples it at the edge ending the RD cycle.
//  - FSM (RD/WR/readMap decoded from state; Xm/Ym from state, cur, d):
//    IDLE: start -> LOAD.
//    LOAD: readMap=1 for 1 cycle; memory sets (0,0) visited -> CHECK.
//    CHECK: cur==goal -> DONE; else -> PROBE.
//    PROBE: RD=1, Xm/Ym=neighbour(cur,d).
//           Dout==0 -> MOVE.
//           Dout==1 & d<3 -> d++, stay in PROBE.
//           Dout==1 & d==3 -> BACK.
//    MOVE: WR=1, Din=1 at neighbour; push d; cur=neighbour; d=0 -> CHECK.
//    BACK: sp==0 -> FAIL. Else pop p; cur steps opposite p.
//          p<3 -> d=p+1, PROBE; p==3 -> stay in BACK (pop again next cycle).
//    DONE/FAIL: hold flag; start re-enters LOAD with sp/d/cur cleared and flags dropped.
//  - Cycle cost: successful probe 2 cycles (PROBE+MOVE) +1 CHECK; failed probe 1; pop 1.
//  - Push never occurs at sp==STACK_DEPTH: one push per newly visited cell, at most 255.
//  - start ignored outside IDLE/DONE/FAIL.
//  - rst mid-run: immediate abort to IDLE. Memory contents are not restored.
// CONFIGURATION
//  - MAZE_PATH_REPLAY_EN defined: DONE first enters REPLAY.
//    REPLAY reads the stack bottom->top, one entry/cycle:
//      move_valid=1, move_dir=entry, for exactly path_len cycles; then done=1.
//    path_len==0 -> done on the next cycle.
//  - Undefined: CHECK goes straight to DONE; move_valid/move_dir tied 0.
// STRUCTURE
//  - maze_defs.vh: direction codes, state encodings, GOAL defaults, coordinate width 5.
//  - Sub-module maze_dir_stack: 2-bit LIFO with push/pop, sp, and an indexed read port for replay.
//  - Top holds the FSM, cur X/Y registers, d counter and neighbour adder.
// TESTING
//  1. All-open map, start -> 15 RIGHT then 15 DOWN; done=1, path_len=30, fail=0.
//     Replay (if enabled): 30 strobes, 15x dir0 then 15x dir1.
//  2. Walls at (1,0),(0,1); start -> probes Xm=1, Ym=1, Xm=31, Ym=31 all blocked.
//     Then BACK at sp=0 -> fail=1, path_len=0.
//  3. Dead end: corridor (0,0)->(3,0) closed, open column at x=0.
//     Rat enters (1..3,0), pops back to (0,0), then goes DOWN; done, path excludes dead end.
//  4. Visited marking: every MOVE has WR=1, Din=1 at the new cell; no cell written twice.
//  5. Right-edge probe at (15,y): Xm=16 observed with RD=1, treated as blocked.
//  6. rst asserted mid-PROBE -> same cycle, all outputs 0, state IDLE.
//     Next start -> LOAD pulse (readMap=1 for one cycle).

Source files
------------

// File: rtl/maze_solver_pkg.sv
// Shared definitions for the maze rat: coordinate width, goal defaults, direction
// codes, controller states and the 5-bit wrapping neighbour step.
package maze_solver_pkg;

  localparam int unsigned COORD_W    = 5;
  localparam int unsigned GOAL_X_DEF = 15;
  localparam int unsigned GOAL_Y_DEF = 15;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_UP    = 2'd3
  } dir_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_PROBE,
    S_MOVE,
    S_BACK,
    S_DONE,
    S_FAIL,
    S_REPLAY
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  // Out-of-range neighbours wrap (0-1 = 31) and read back as walls from memory.
  function automatic coord_t step(input coord_t c, input logic [1:0] d);
    coord_t n;
    n = c;
    case (dir_t'(d))
      DIR_RIGHT: n.x = c.x + 5'd1;
      DIR_DOWN:  n.y = c.y + 5'd1;
      DIR_LEFT:  n.x = c.x - 5'd1;
      default:   n.y = c.y - 5'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/maze_solver_dir_stack.sv
// 2-bit direction LIFO holding the moves taken from the start cell.
// With MAZE_PATH_REPLAY_EN an extra indexed read port exposes entries bottom->top.
module maze_dir_stack #(
  parameter int unsigned DEPTH = 256,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [1:0]    push_dir,
`ifdef MAZE_PATH_REPLAY_EN
  input  logic [AW-1:0] rd_idx,
  output logic [1:0]    rd_dir,
`endif
  output logic [1:0]    top_dir,
  output logic [AW-1:0] sp
);

  logic [1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        sp <= '0;
    else if (clear) sp <= '0;
    else if (push)  sp <= sp + 1'b1;
    else if (pop)   sp <= sp - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[sp] <= push_dir;
  end

  assign top_dir = mem[sp - 1'b1];

`ifdef MAZE_PATH_REPLAY_EN
  assign rd_dir = mem[rd_idx];
`endif

endmodule

// File: rtl/maze_solver.sv
// Depth-first maze rat: loads the map, then walks (0,0) -> goal over the maze-memory port.
// Define MAZE_PATH_REPLAY_EN to replay the stacked path one direction per cycle before done.
module maze_solver
  import maze_solver_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 256,
  parameter int unsigned GOAL_X      = GOAL_X_DEF,
  parameter int unsigned GOAL_Y      = GOAL_Y_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       Dout,
  output logic [4:0] Xm,
  output logic [4:0] Ym,
  output logic       Din,
  output logic       readMap,
  output logic       RD,
  output logic       WR,
  output logic       done,
  output logic       fail,
  output logic [7:0] path_len,
  output logic       move_valid,
  output logic [1:0] move_dir
);

  localparam int unsigned AW = $clog2(STACK_DEPTH);
  localparam logic [COORD_W-1:0] GX = COORD_W'(GOAL_X);
  localparam logic [COORD_W-1:0] GY = COORD_W'(GOAL_Y);

  state_t        state, state_next;
  coord_t        cur, cur_next, nb;
  logic [1:0]    d, d_next;
  logic          push, pop, clear;
  logic [1:0]    top_dir;
  logic [AW-1:0] sp;

`ifdef MAZE_PATH_REPLAY_EN
  logic [AW-1:0] idx, idx_next;
  logic [1:0]    rd_dir;
`endif

  maze_dir_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .push     (push),
    .pop      (pop),
    .push_dir (d),
`ifdef MAZE_PATH_REPLAY_EN
    .rd_idx   (idx),
    .rd_dir   (rd_dir),
`endif
    .top_dir  (top_dir),
    .sp       (sp)
  );

  assign nb       = step(cur, d);
  assign path_len = 8'(sp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cur   <= '0;
      d     <= '0;
    end else begin
      state <= state_next;
      cur   <= cur_next;
      d     <= d_next;
    end
  end

`ifdef MAZE_PATH_REPLAY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) idx <= '0;
    else     idx <= idx_next;
  end
`endif

  always_comb begin
    state_next = state;
    cur_next   = cur;
    d_next     = d;
    push       = 1'b0;
    pop        = 1'b0;
    clear      = 1'b0;
    Xm         = '0;
    Ym         = '0;
    Din        = 1'b0;
    readMap    = 1'b0;
    RD         = 1'b0;
    WR         = 1'b0;
    done       = 1'b0;
    fail       = 1'b0;
    move_valid = 1'b0;
    move_dir   = '0;
`ifdef MAZE_PATH_REPLAY_EN
    idx_next   = idx;
`endif
    case (state)
      S_IDLE, S_DONE, S_FAIL: begin
        done = (state == S_DONE);
        fail = (state == S_FAIL);
        if (start) begin
          state_next = S_LOAD;
          clear      = 1'b1;
          cur_next   = '0;
          d_next     = '0;
        end
      end
      S_LOAD: begin
        readMap    = 1'b1;
        state_next = S_CHECK;
      end
      S_CHECK: begin
        if (cur.x == GX && cur.y == GY) begin
`ifdef MAZE_PATH_REPLAY_EN
          state_next = S_REPLAY;
          idx_next   = '0;
`else
          state_next = S_DONE;
`endif
        end else begin
          state_next = S_PROBE;
        end
      end
      S_PROBE: begin
        RD = 1'b1;
        Xm = nb.x;
        Ym = nb.y;
        if (!Dout)              state_next = S_MOVE;
        else if (d != DIR_UP)   d_next = d + 2'd1;
        else                    state_next = S_BACK;
      end
      S_MOVE: begin
        WR         = 1'b1;
        Din        = 1'b1;
        Xm         = nb.x;
        Ym         = nb.y;
        push       = 1'b1;
        cur_next   = nb;
        d_next     = '0;
        state_next = S_CHECK;
      end
      S_BACK: begin
        // Step opposite the popped move; a popped UP has no directions left, so pop again.
        if (sp == '0) begin
          state_next = S_FAIL;
        end else begin
          pop      = 1'b1;
          cur_next = step(cur, top_dir ^ 2'b10);
          if (top_dir != DIR_UP) begin
            d_next     = top_dir + 2'd1;
            state_next = S_PROBE;
          end
        end
      end
      S_REPLAY: begin
`ifdef MAZE_PATH_REPLAY_EN
        if (idx == sp) begin
          state_next = S_DONE;
        end else begin
          move_valid = 1'b1;
          move_dir   = rd_dir;
          idx_next   = idx + 1'b1;
        end
`else
        state_next = S_DONE;
`endif
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_maze_solver.sv
// Self-checking bench for maze_solver: a behavioural maze memory plus a depth-first
// reference walk predicting outcome, path, move count and cycle count.
module tb_maze_solver;

  logic       clk = 1'b0;
  logic       rst, start, Dout;
  logic [4:0] Xm, Ym;
  logic       Din, readMap, RD, WR, done, fail, move_valid;
  logic [7:0] path_len;
  logic [1:0] move_dir;

  always #5 clk = ~clk;

  maze_solver dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .Dout       (Dout),
    .Xm         (Xm),
    .Ym         (Ym),
    .Din        (Din),
    .readMap    (readMap),
    .RD         (RD),
    .WR         (WR),
    .done       (done),
    .fail       (fail),
    .path_len   (path_len),
    .move_valid (move_valid),
    .move_dir   (move_dir)
  );

  localparam int GOAL = 15;
  localparam int LIMIT = 20000;

  logic [15:0] maze [16];
  logic [15:0] mem  [16];
  logic [9:0]  probe_log [$];
  logic [9:0]  wr_log [$];

  int checks = 0;
  int failures = 0;

  bit exp_ok;
  int exp_cycles;
  int exp_moves;
  int exp_path [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Maze memory: out-of-range coordinates read as walls
  assign Dout = (Xm > 5'd15 || Ym > 5'd15) ? 1'b1 : mem[Ym[3:0]][Xm[3:0]];

  always @(posedge clk) begin
    if (RD) probe_log.push_back({Xm, Ym});
    if (readMap) begin
      mem <= maze;
      mem[0][0] <= 1'b1;
    end else if (WR) begin
      wr_log.push_back({Xm, Ym});
      check("wr_din", Din, 1);
      check("wr_in_range", (Xm < 5'd16 && Ym < 5'd16), 1);
      if (Xm < 5'd16 && Ym < 5'd16) begin
        check("wr_fresh_cell", mem[Ym[3:0]][Xm[3:0]], 0);
        mem[Ym[3:0]][Xm[3:0]] <= 1'b1;
      end
    end
  end

  task automatic clear_maze();
    foreach (maze[i]) maze[i] = '0;
  endtask

  // Reference depth-first walk on signed grid coordinates with cycle accounting.
  task automatic run_model();
    int dx [4] = '{1, 0, -1, 0};
    int dy [4] = '{0, 1, 0, -1};
    bit vis [16][16];
    int x, y, nx, ny, d, p;
    bit arrived;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) vis[r][c] = maze[r][c];
    vis[0][0] = 1'b1;
    exp_path.delete();
    exp_moves = 0;
    x = 0; y = 0; d = 0;
    arrived = 1'b1;
    exp_cycles = 1;
    forever begin
      if (arrived) begin
        exp_cycles++;
        if (x == GOAL && y == GOAL) begin
          exp_ok = 1'b1;
          break;
        end
        d = 0;
        arrived = 1'b0;
      end
      if (d < 4) begin
        nx = x + dx[d];
        ny = y + dy[d];
        exp_cycles++;
        if (nx >= 0 && nx < 16 && ny >= 0 && ny < 16 && !vis[ny][nx]) begin
          exp_cycles++;
          vis[ny][nx] = 1'b1;
          exp_path.push_back(d);
          exp_moves++;
          x = nx; y = ny;
          arrived = 1'b1;
        end else begin
          d++;
        end
      end else begin
        exp_cycles++;
        if (exp_path.size() == 0) begin
          exp_ok = 1'b0;
          break;
        end
        p = exp_path.pop_back();
        x -= dx[p];
        y -= dy[p];
        d = p + 1;
      end
    end
`ifdef MAZE_PATH_REPLAY_EN
    if (exp_ok) exp_cycles += exp_path.size() + 1;
`endif
  endtask

  // Called at a negedge with the DUT in IDLE/DONE/FAIL.
  task automatic run_maze();
    int cyc = 0;
    int rm = 0;
    int rep [$];
    run_model();
    probe_log.delete();
    wr_log.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!(done || fail) && cyc < LIMIT) begin
      cyc++;
      if (readMap) rm++;
      if (move_valid) rep.push_back(move_dir);
      @(negedge clk);
    end
    check("timeout", cyc < LIMIT, 1);
    check("readmap_pulses", rm, 1);
    check("done", done, exp_ok);
    check("fail", fail, !exp_ok);
    check("path_len", path_len, exp_path.size());
    check("cycles", cyc, exp_cycles);
    check("moves", wr_log.size(), exp_moves);
`ifdef MAZE_PATH_REPLAY_EN
    check("replay_len", rep.size(), exp_ok ? exp_path.size() : 0);
    foreach (rep[i])
      if (i < exp_path.size()) check("replay_dir", rep[i], exp_path[i]);
`else
    check("replay_len", rep.size(), 0);
`endif
    repeat (2) @(negedge clk);
    check("flag_hold", {done, fail}, {exp_ok, !exp_ok});
  endtask

  initial begin
    logic [9:0] exp_probe [4];
    int n16;
    int k;
    int dens;

    rst = 1'b1;
    start = 1'b0;
    clear_maze();
    #1;
    check("reset_outputs",
          {Xm, Ym, Din, readMap, RD, WR, done, fail, path_len, move_valid, move_dir}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // All-open map: 15 RIGHT then 15 DOWN, right-edge probes read as blocked
    clear_maze();
    run_maze();
    check("open_done", done, 1);
    check("open_len", path_len, 30);
    n16 = 0;
    foreach (probe_log[i]) if (probe_log[i][9:5] == 5'd16) n16++;
    check("open_edge_probes", n16, 15);
    check("open_last_write", (wr_log.size() > 0) ? wr_log[wr_log.size()-1] : 10'h0,
          {5'd15, 5'd15});

    // Boxed-in start: four blocked probes then failure
    clear_maze();
    maze[0][1] = 1'b1;
    maze[1][0] = 1'b1;
    run_maze();
    check("boxed_fail", fail, 1);
    check("boxed_len", path_len, 0);
    check("boxed_probe_count", probe_log.size(), 4);
    exp_probe[0] = {5'd1, 5'd0};
    exp_probe[1] = {5'd0, 5'd1};
    exp_probe[2] = {5'd31, 5'd0};
    exp_probe[3] = {5'd0, 5'd31};
    for (int i = 0; i < 4; i++)
      if (i < probe_log.size()) check("boxed_probe", probe_log[i], exp_probe[i]);

    // Dead-end corridor along row 0, escape down column 0
    clear_maze();
    maze[1][1] = 1'b1;
    maze[1][2] = 1'b1;
    maze[1][3] = 1'b1;
    maze[0][4] = 1'b1;
    run_maze();
    check("deadend_done", done, 1);
    check("deadend_escape", (wr_log.size() > 3) ? wr_log[3] : 10'h3ff, {5'd0, 5'd1});

    // Reset mid-probe, then a clean restart
    clear_maze();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(RD && path_len > 8'd3) && k < 1000) begin
      k++;
      @(negedge clk);
    end
    check("reach_probe", k < 1000, 1);
    #2 rst = 1'b1;
    #1;
    check("midrun_reset_outputs",
          {Xm, Ym, Din, readMap, RD, WR, done, fail, path_len, move_valid, move_dir}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_maze();

    // Random mazes
    for (int t = 0; t < 20; t++) begin
      dens = $urandom_range(10, 45);
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++)
          maze[r][c] = ($urandom_range(0, 99) < dens);
      maze[0][0] = 1'b0;
      run_maze();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
